flit_injector: RTL

- Network-interface transmit block: converts a packet request (destination plus a stream of payload words) into a typed flit stream.
- Drives a router input port over the data/valid/ready flit interface.
- Emits one HEAD flit, then FlitPerPacket-1 payload flits; the last payload flit is typed TAIL, the rest BODY.
- Sits between a traffic source (core or test generator) and a router port's data_in/valid_in/ready_in.

---
 rtl/flit_injector_if.sv | 28 ++
 rtl/flit_injector.sv | 118 +++++++++++
 2 files changed

// File: rtl/flit_injector_if.sv
// Packet-request, payload and flit-output signals between a traffic source, flit_injector and a router port.
// The master modport is the injector side; the slave modport is the source/router side.
interface flit_injector_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TYPE_WIDTH = 2,
  parameter int DEST_WIDTH = 2
);
  logic                             pkt_valid;
  logic                             pkt_ready;
  logic [DEST_WIDTH-1:0]            pkt_dest;
  logic [DATA_WIDTH-TYPE_WIDTH-1:0] payload_data;
  logic                             payload_valid;
  logic                             payload_ready;
  logic [DATA_WIDTH-1:0]            data_out;
  logic                             valid_out;
  logic                             ready_out;
  logic                             busy;

  modport master (
    input  pkt_valid, pkt_dest, payload_data, payload_valid, ready_out,
    output pkt_ready, payload_ready, data_out, valid_out, busy
  );

  modport slave (
    output pkt_valid, pkt_dest, payload_data, payload_valid, ready_out,
    input  pkt_ready, payload_ready, data_out, valid_out, busy
  );
endinterface

// File: rtl/flit_injector.sv
// Turns a packet request plus payload words into HEAD/BODY.../TAIL flits; SRC_ID_EN puts INDEX into the head.
// Latency: one register stage, a handshake at edge k drives data_out/valid_out from edge k.
// Backpressure: a presented flit holds until ready_out; both request readies follow the free output slot.
module flit_injector #(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int TYPE_WIDTH    = 2,
  parameter int DEST_WIDTH    = 2,
  parameter int FlitPerPacket = 6
) (
  input  logic             clk,
  input  logic             rst,
  flit_injector_if.master  bus
);

  localparam int PAY_W = DATA_WIDTH - TYPE_WIDTH;
  localparam int CNT_W = $clog2(FlitPerPacket);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(FlitPerPacket - 2);
  localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TYPE_BODY = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL = TYPE_WIDTH'(3);

`ifdef SRC_ID_EN
  localparam bit SRC_FITS = (2 * DEST_WIDTH) <= PAY_W;
`else
  localparam bit SRC_FITS = 1'b1;
`endif
  localparam bit CFG_OK = (FlitPerPacket >= 2) && (INDEX < N) &&
                          (N <= (1 << DEST_WIDTH)) && SRC_FITS;

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("flit_injector: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  slot_free;
  logic                  pkt_ready;
  logic                  payload_ready;
  logic [DATA_WIDTH-1:0] head_flit;

  always_comb begin
    head_flit                              = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]  = TYPE_HEAD;
    head_flit[DEST_WIDTH-1:0]              = bus.pkt_dest;
`ifdef SRC_ID_EN
    head_flit[2*DEST_WIDTH-1 -: DEST_WIDTH] = DEST_WIDTH'(INDEX);
`endif
  end

  always_comb begin
    slot_free     = !valid_q || bus.ready_out;
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    // An occupied slot that is not taken keeps its flit; a free slot empties unless reloaded below.
    valid_d       = slot_free ? 1'b0 : valid_q;
    pkt_ready     = 1'b0;
    payload_ready = 1'b0;

    case (state_q)
      IDLE: begin
        pkt_ready = slot_free;
        if (bus.pkt_valid && slot_free) begin
          data_d  = head_flit;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        payload_ready = slot_free;
        if (bus.payload_valid && slot_free) begin
          valid_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            data_d  = {TYPE_TAIL, bus.payload_data};
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            data_d  = {TYPE_BODY, bus.payload_data};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.busy          = (state_q == PAYLOAD);
  assign bus.pkt_ready     = pkt_ready;
  assign bus.payload_ready = payload_ready;

endmodule
